// File: rtl/neuron_mac.sv
// Fixed-point neuron pre-activation: streams N_INPUTS (x, w) pairs, accumulates
// the full products, adds bias, rounds half toward +inf and saturates to DATA_W.
module neuron_mac #(
    parameter int N_INPUTS = 8,
    parameter int DATA_W   = 17,
    parameter int FRAC_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_w,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sat
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + $clog2(N_INPUTS) + 1;
    // One extra bit so bias and rounding offset can never wrap the sum.
    localparam int T_W    = ACC_W + 1;
    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

    localparam logic signed [T_W-1:0] HALF    = {{(T_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
    localparam logic signed [T_W-1:0] SAT_MAX = {{(T_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [T_W-1:0] SAT_MIN = {{(T_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]     OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]     OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_RND = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t                    state_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic        [CNT_W-1:0]   cnt_r;

    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   acc_next_s;
    logic signed [T_W-1:0]     rnd_t_s;
    logic signed [T_W-1:0]     rnd_r_s;
    logic        [DATA_W-1:0]  sat_data_s;
    logic                      sat_flag_s;

    assign prod_s     = $signed({{DATA_W{in_x[DATA_W-1]}}, in_x})
                      * $signed({{DATA_W{in_w[DATA_W-1]}}, in_w});
    assign acc_next_s = acc_r + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    assign rnd_t_s    = {acc_r[ACC_W-1], acc_r}
                      + ({{(T_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_W)
                      + HALF;
    assign rnd_r_s    = rnd_t_s >>> FRAC_W;

    // Clamp the rounded sum into the signed DATA_W output range.
    always_comb begin
        sat_data_s = rnd_r_s[DATA_W-1:0];
        sat_flag_s = 1'b0;
        if (rnd_r_s > SAT_MAX) begin
            sat_data_s = OUT_MAX;
            sat_flag_s = 1'b1;
        end else if (rnd_r_s < SAT_MIN) begin
            sat_data_s = OUT_MIN;
            sat_flag_s = 1'b1;
        end else begin
            sat_data_s = rnd_r_s[DATA_W-1:0];
            sat_flag_s = 1'b0;
        end
    end

    // Control FSM with accumulator, pair counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_ACC;
            acc_r     <= ACC_ZERO;
            cnt_r     <= CNT_ZERO;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= {DATA_W{1'b0}};
            out_sat   <= 1'b0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (in_valid && in_ready) begin
                        acc_r <= acc_next_s;
                        if (cnt_r == CNT_LAST) begin
                            cnt_r    <= CNT_ZERO;
                            in_ready <= 1'b0;
                            state_r  <= ST_RND;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_RND: begin
                    out_data  <= sat_data_s;
                    out_sat   <= sat_flag_s;
                    out_valid <= 1'b1;
                    state_r   <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        acc_r     <= ACC_ZERO;
                        in_ready  <= 1'b1;
                        state_r   <= ST_ACC;
                    end
                end
                default: begin
                    state_r   <= ST_ACC;
                    acc_r     <= ACC_ZERO;
                    cnt_r     <= CNT_ZERO;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: cycle-level reference model plus
// directed literal cases and randomized transactions with stalls and backpressure.
module tb_neuron_mac;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, out_valid, out_ready, out_sat;
    logic signed [16:0] in_x, in_w, bias, out_data;

    int total = 0;
    int bad   = 0;

    // Reference model state and results captured at each output handshake.
    longint m_sum, m_data;
    int     m_cnt;
    bit     m_rnd, m_ready, m_valid, m_sat, m_ok;
    longint got_data, mdl_data;
    bit     got_sat, mdl_sat;
    int     n_hs = 0;

    logic signed [16:0] tx_x [N];
    logic signed [16:0] tx_w [N];

    always #5 clk = ~clk;

    neuron_mac #(.N_INPUTS(N), .DATA_W(17), .FRAC_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outputs compared at negedge, state advanced from inputs seen at posedge.
    initial begin : model
        longint t, r;
        m_ok = 1'b0; m_sum = 0; m_cnt = 0; m_rnd = 1'b0;
        m_ready = 1'b1; m_valid = 1'b0; m_data = 0; m_sat = 1'b0;
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("in_ready", longint'(in_ready), longint'(m_ready));
                chk("out_valid", longint'(out_valid), longint'(m_valid));
                if (m_valid) begin
                    chk("out_data", longint'(out_data), m_data);
                    chk("out_sat", longint'(out_sat), longint'(m_sat));
                end
            end
            @(posedge clk);
            if (!reset) begin
                m_sum = 0; m_cnt = 0; m_rnd = 1'b0; m_ready = 1'b1;
                m_valid = 1'b0; m_data = 0; m_sat = 1'b0; m_ok = 1'b1;
            end else if (m_rnd) begin
                t = m_sum + longint'(bias) * 256 + 128;
                r = t >>> 8;
                if (r > 65535) begin
                    m_data = 65535; m_sat = 1'b1;
                end else if (r < -65536) begin
                    m_data = -65536; m_sat = 1'b1;
                end else begin
                    m_data = r; m_sat = 1'b0;
                end
                m_valid = 1'b1;
                m_rnd   = 1'b0;
            end else if (m_valid) begin
                if (out_ready) begin
                    got_data = longint'(out_data);
                    got_sat  = out_sat;
                    mdl_data = m_data;
                    mdl_sat  = m_sat;
                    n_hs++;
                    m_valid = 1'b0;
                    m_ready = 1'b1;
                    m_sum   = 0;
                end
            end else if (in_valid) begin
                m_sum += longint'(in_x) * longint'(in_w);
                m_cnt++;
                if (m_cnt == N) begin
                    m_cnt   = 0;
                    m_rnd   = 1'b1;
                    m_ready = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic signed [16:0] x, input logic signed [16:0] w, input int gap);
        int guard;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_x = 17'($urandom);
            in_w = 17'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_x = x;
        in_w = w;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 100) begin
            bad++;
            $display("FAIL push_wait: in_ready low for %0d cycles, expected acceptance", guard);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int hold);
        int guard;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 100) begin
            bad++;
            $display("FAIL out_wait: out_valid low for %0d cycles, expected a result", guard);
        end
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            in_x      = 17'($urandom);
            in_w      = 17'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic txn(input logic signed [16:0] b, input int gapmax, input int hold);
        bias = b;
        for (int i = 0; i < N; i++) push(tx_x[i], tx_w[i], $urandom_range(0, gapmax));
        collect(hold);
    endtask

    task automatic fill(input logic signed [16:0] x0, input logic signed [16:0] w0,
                        input logic signed [16:0] xr, input logic signed [16:0] wr);
        tx_x[0] = x0;
        tx_w[0] = w0;
        for (int i = 1; i < N; i++) begin
            tx_x[i] = xr;
            tx_w[i] = wr;
        end
    endtask

    task automatic expect_result(input string name, input longint d, input longint s);
        chk({name, "_dut"}, got_data, d);
        chk({name, "_mdl"}, mdl_data, d);
        chk({name, "_sat"}, longint'(got_sat), s);
        chk({name, "_msat"}, longint'(mdl_sat), s);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int hs0;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        bias = 17'sd0; in_x = 17'sd0; in_w = 17'sd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_sat", longint'(out_sat), 0);
        reset = 1'b1;
        @(negedge clk);

        fill(17'sd256, 17'sd256, 17'sd256, 17'sd256);
        txn(17'sd0, 0, 0);
        expect_result("basic", 1024, 0);

        fill(17'sd1, 17'sd128, 17'sd0, 17'sd0);
        txn(17'sd0, 0, 0);
        expect_result("round_half_up", 1, 0);
        fill(17'sd1, 17'sd127, 17'sd0, 17'sd0);
        txn(17'sd0, 0, 0);
        expect_result("round_below_half", 0, 0);
        fill(-17'sd1, 17'sd128, 17'sd0, 17'sd0);
        txn(17'sd0, 0, 0);
        expect_result("round_neg_half", 0, 0);

        fill(17'sd65535, 17'sd65535, 17'sd65535, 17'sd65535);
        txn(17'sd0, 0, 0);
        expect_result("sat_pos", 65535, 1);
        fill(-17'sd65536, 17'sd65535, -17'sd65536, 17'sd65535);
        txn(17'sd0, 0, 0);
        expect_result("sat_neg", -65536, 1);
        fill(17'sd0, 17'sd0, 17'sd0, 17'sd0);
        txn(17'sd256, 0, 0);
        expect_result("bias_only", 256, 0);

        fill(17'sd256, 17'sd256, 17'sd256, 17'sd256);
        txn(17'sd0, 0, 5);
        expect_result("backpressure", 1024, 0);

        hs0 = n_hs;
        bias = 17'sd0;
        push(17'sd256, 17'sd256, 0);
        push(17'sd256, 17'sd256, 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        txn(17'sd0, 0, 0);
        expect_result("reset_midop", 1024, 0);
        chk("reset_midop_count", longint'(n_hs), longint'(hs0 + 1));

        txn(17'sd0, 6, 0);
        expect_result("stall", 1024, 0);

        hs0 = n_hs;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                if (k < 20) begin
                    tx_x[i] = 17'($urandom);
                    tx_w[i] = 17'($urandom);
                end else begin
                    tx_x[i] = 17'($signed(10'($urandom)));
                    tx_w[i] = 17'($signed(10'($urandom)));
                end
            end
            txn(17'($urandom), 3, $urandom_range(0, 3));
            chk("rand_result", got_data, mdl_data);
        end
        chk("rand_count", longint'(n_hs), longint'(hs0 + 40));

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
